operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 45 ++++
 rtl/operand_fetch.sv | 114 +++++++++++
 tb/tb_operand_fetch.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch bundle: decode issue, writeback and ALU-side handshakes.
// slave = operand_fetch, master = surrounding pipeline / bench.
interface operand_fetch_if;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned OP_W   = 3;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [IDX_W-1:0]  in_rs1;
   logic [IDX_W-1:0]  in_rs2;
   logic [IDX_W-1:0]  in_rd;
   logic              in_wr;
   logic              in_use_imm;
   logic [DATA_W-1:0] in_imm;

   logic              wb_en;
   logic [IDX_W-1:0]  wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] operand1;
   logic [DATA_W-1:0] operand2;
   logic [OP_W-1:0]   operation;
   logic [IDX_W-1:0]  out_rd;
   logic              out_wr;

   modport master (
      output in_valid, in_op, in_rs1, in_rs2, in_rd, in_wr, in_use_imm, in_imm,
      input  in_ready,
      output wb_en, wb_addr, wb_data,
      input  out_valid, operand1, operand2, operation, out_rd, out_wr,
      output out_ready
   );

   modport slave (
      input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_wr, in_use_imm, in_imm,
      output in_ready,
      input  wb_en, wb_addr, wb_data,
      output out_valid, operand1, operand2, operation, out_rd, out_wr,
      input  out_ready
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x16 register file with writeback bypass, pending-write
// scoreboard for RAW stalls, and a single registered ALU operand bundle.
module operand_fetch (
   input logic           clk,
   input logic           reset,
   operand_fetch_if.slave bus
);
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned OP_W     = 3;
   localparam int unsigned NUM_REGS = 8;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt_c;

   logic                rs1_byp_c;
   logic                rs2_byp_c;
   logic [DATA_W-1:0]   rs1_val_c;
   logic [DATA_W-1:0]   rs2_val_c;
   logic                hazard_c;
   logic                in_ready_c;
   logic                accept_c;

   logic                out_valid_q;
   logic [DATA_W-1:0]   operand1_q;
   logic [DATA_W-1:0]   operand2_q;
   logic [OP_W-1:0]     operation_q;
   logic [IDX_W-1:0]    out_rd_q;
   logic                out_wr_q;

   // Source reads with same-cycle writeback bypass; r0 is hardwired to zero.
   always_comb begin
      rs1_byp_c = bus.wb_en && (bus.wb_addr == bus.in_rs1);
      rs2_byp_c = bus.wb_en && (bus.wb_addr == bus.in_rs2);

      if (bus.in_rs1 == IDX_W'(0))
         rs1_val_c = '0;
      else if (rs1_byp_c)
         rs1_val_c = bus.wb_data;
      else
         rs1_val_c = regs[bus.in_rs1];

      if (bus.in_rs2 == IDX_W'(0))
         rs2_val_c = '0;
      else if (rs2_byp_c)
         rs2_val_c = bus.wb_data;
      else
         rs2_val_c = regs[bus.in_rs2];
   end

   // A writeback landing this cycle resolves the hazard via the bypass.
   always_comb begin
      hazard_c   = (pending[bus.in_rs1] && !rs1_byp_c) ||
                   (!bus.in_use_imm && pending[bus.in_rs2] && !rs2_byp_c);
      in_ready_c = !hazard_c && (!out_valid_q || bus.out_ready);
      accept_c   = bus.in_valid && in_ready_c;
   end

   // Clear on writeback first so a same-cycle issue to that index re-marks it.
   always_comb begin
      pending_nxt_c = pending;
      if (bus.wb_en)
         pending_nxt_c[bus.wb_addr] = 1'b0;
      if (accept_c && bus.in_wr && (bus.in_rd != IDX_W'(0)))
         pending_nxt_c[bus.in_rd] = 1'b1;
      pending_nxt_c[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pending <= '0;
      else
         pending <= pending_nxt_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (bus.wb_en && (bus.wb_addr != IDX_W'(0))) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Output bundle: load on accept, drop valid when consumed, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         operand1_q  <= '0;
         operand2_q  <= '0;
         operation_q <= '0;
         out_rd_q    <= '0;
         out_wr_q    <= 1'b0;
      end else if (accept_c) begin
         out_valid_q <= 1'b1;
         operand1_q  <= rs1_val_c;
         operand2_q  <= bus.in_use_imm ? bus.in_imm : rs2_val_c;
         operation_q <= bus.in_op;
         out_rd_q    <= bus.in_rd;
         out_wr_q    <= bus.in_wr;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.operand1  = operand1_q;
   assign bus.operand2  = operand2_q;
   assign bus.operation = operation_q;
   assign bus.out_rd    = out_rd_q;
   assign bus.out_wr    = out_wr_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic checked
// every cycle against a behavioural register-file/scoreboard model.
module tb_operand_fetch;
   logic clk = 1'b0;
   logic reset;

   operand_fetch_if bus ();

   operand_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [15:0] m_regs [8];
   logic [7:0]  m_pend;
   logic        m_valid;
   logic [15:0] m_op1, m_op2;
   logic [2:0]  m_opc, m_rd;
   logic        m_wr;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_pend  = 8'h0;
      m_valid = 1'b0;
      m_op1   = 16'h0;
      m_op2   = 16'h0;
      m_opc   = 3'h0;
      m_rd    = 3'h0;
      m_wr    = 1'b0;
   endtask

   function automatic logic bypassed(input logic [2:0] idx);
      return bus.wb_en && (bus.wb_addr == idx);
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] idx);
      if (idx == 3'd0) return 16'h0;
      if (bypassed(idx)) return bus.wb_data;
      return m_regs[idx];
   endfunction

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.in_op      = 3'h0;
      bus.in_rs1     = 3'h0;
      bus.in_rs2     = 3'h0;
      bus.in_rd      = 3'h0;
      bus.in_wr      = 1'b0;
      bus.in_use_imm = 1'b0;
      bus.in_imm     = 16'h0;
      bus.wb_en      = 1'b0;
      bus.wb_addr    = 3'h0;
      bus.wb_data    = 16'h0;
      bus.out_ready  = 1'b1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic wr, input logic use_imm,
                        input logic [15:0] imm);
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_rs1     = rs1;
      bus.in_rs2     = rs2;
      bus.in_rd      = rd;
      bus.in_wr      = wr;
      bus.in_use_imm = use_imm;
      bus.in_imm     = imm;
   endtask

   // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
   task automatic step(output logic rdy);
      logic        hz, exp_rdy, acc;
      logic [15:0] r1, r2;
      #1;
      hz = (m_pend[bus.in_rs1] && !bypassed(bus.in_rs1)) ||
           (!bus.in_use_imm && m_pend[bus.in_rs2] && !bypassed(bus.in_rs2));
      exp_rdy = !hz && (!m_valid || bus.out_ready);
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      rdy = bus.in_ready;
      acc = bus.in_valid && exp_rdy;
      r1  = m_read(bus.in_rs1);
      r2  = bus.in_use_imm ? bus.in_imm : m_read(bus.in_rs2);
      if (acc) begin
         m_valid = 1'b1;
         m_op1   = r1;
         m_op2   = r2;
         m_opc   = bus.in_op;
         m_rd    = bus.in_rd;
         m_wr    = bus.in_wr;
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
      end
      if (bus.wb_en) begin
         if (bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
         m_pend[bus.wb_addr] = 1'b0;
      end
      if (acc && bus.in_wr && bus.in_rd != 3'd0) m_pend[bus.in_rd] = 1'b1;
      @(posedge clk);
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("operand1",  32'(bus.operand1),  32'(m_op1));
      check("operand2",  32'(bus.operand2),  32'(m_op2));
      check("operation", 32'(bus.operation), 32'(m_opc));
      check("out_rd",    32'(bus.out_rd),    32'(m_rd));
      check("out_wr",    32'(bus.out_wr),    32'(m_wr));
      check("pending",   32'(dut.pending),   32'(m_pend));
   endtask

   logic        rdy;
   logic [15:0] held_op2;
   int          accepts = 0;

   initial begin
      model_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_operand1",  32'(bus.operand1),  32'd0);
      check("rst_operation", 32'(bus.operation), 32'd0);
      check("rst_pending",   32'(dut.pending),   32'd0);
      reset = 1'b0;

      // Writeback r2 then read it with an immediate operand.
      bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'h1234;
      step(rdy);
      idle();
      issue(3'd4, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0005);
      step(rdy);
      check("d035_valid", 32'(bus.out_valid), 32'd1);
      check("d035_op1",   32'(bus.operand1),  32'h1234);
      check("d035_op2",   32'(bus.operand2),  32'h0005);
      check("d035_opc",   32'(bus.operation), 32'd4);

      // RAW hazard on r4 resolved by a same-cycle writeback.
      idle();
      issue(3'd1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 16'h0);
      step(rdy);
      idle();
      issue(3'd2, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0009);
      step(rdy);
      check("d036_stall", 32'(rdy), 32'd0);
      bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.wb_data = 16'hBEEF;
      step(rdy);
      check("d036_bypass_ready", 32'(rdy), 32'd1);
      check("d036_op1", 32'(bus.operand1), 32'hBEEF);
      check("d036_pend4", 32'(dut.pending[4]), 32'd0);

      // Backpressure holds the bundle for 3 cycles.
      idle();
      issue(3'd3, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1, 16'h00AA);
      step(rdy);
      issue(3'd6, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0077);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(rdy);
         check("d037_stall_ready", 32'(rdy), 32'd0);
         check("d037_hold_op2", 32'(bus.operand2), 32'h00AA);
         check("d037_hold_opc", 32'(bus.operation), 32'd3);
      end
      bus.out_ready = 1'b1;
      step(rdy);
      check("d037_release_ready", 32'(rdy), 32'd1);
      check("d037_next_opc", 32'(bus.operation), 32'd6);
      check("d037_next_op2", 32'(bus.operand2), 32'h0077);

      // Writes to r0 are ignored.
      idle();
      bus.wb_en = 1'b1; bus.wb_addr = 3'd0; bus.wb_data = 16'hFFFF;
      step(rdy);
      idle();
      issue(3'd5, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 16'hFFFF);
      step(rdy);
      check("d038_ready", 32'(rdy), 32'd1);
      check("d038_op1", 32'(bus.operand1), 32'd0);
      check("d038_op2", 32'(bus.operand2), 32'd0);

      // Same-cycle set and clear of r5: set wins.
      idle();
      issue(3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 16'h0);
      bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 16'h5555;
      step(rdy);
      check("d039_pend5", 32'(dut.pending[5]), 32'd1);

      // Asynchronous reset with a held bundle and r3 pending.
      idle();
      issue(3'd7, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 16'h1111);
      bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h3333;
      step(rdy);
      idle();
      bus.out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("d040_valid", 32'(bus.out_valid), 32'd0);
      check("d040_pending", 32'(dut.pending), 32'd0);
      check("d040_op1", 32'(bus.operand1), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      issue(3'd1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 16'h0);
      step(rdy);
      check("d040_r3_ready", 32'(rdy), 32'd1);
      check("d040_r3_op1", 32'(bus.operand1), 32'd0);
      check("d040_r3_op2", 32'(bus.operand2), 32'd0);

      // Randomized traffic; writebacks mostly target pending registers.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [2:0] wa;
         idle();
         if ($urandom_range(0, 9) < 7)
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 4) begin
            wa = 3'($urandom);
            if (m_pend != 8'h0 && $urandom_range(0, 3) != 0) begin
               for (int t = 0; t < 16 && !m_pend[wa]; t++) wa = 3'($urandom);
            end
            bus.wb_en   = 1'b1;
            bus.wb_addr = wa;
            bus.wb_data = 16'($urandom);
         end
         step(rdy);
         if (rdy && bus.in_valid) accepts++;
      end
      tests++;
      if (accepts < 300) begin
         fails++;
         $display("FAIL random_accepts: got %0d expected at least 300", accepts);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
